// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared encodings for the up/down modulo-N counter family.
//                Mode and direction values match the single-bit control
//                inputs sat and up.
//  Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

    // Counting mode, as driven on the sat input
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Counting direction, as driven on the up input
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/updown_modn_counter_next.sv
`default_nettype none
// ============================================================================
//  Module      : updown_next
//  Description : Combinational next-count and pulse logic for one enabled
//                step of the up/down modulo-N counter.
//                Ports: q, max_r (current count and bound), up, sat (control)
//                       -> q_next, carry_n, borrow_n, sat_n.
//  Revision    : 1.0  initial release
// ============================================================================
module updown_next
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] max_r,
    input  logic             up,
    input  logic             sat,
    output logic [WIDTH-1:0] q_next,
    output logic             carry_n,
    output logic             borrow_n,
    output logic             sat_n
);

    always_comb begin
        q_next   = q;
        carry_n  = 1'b0;
        borrow_n = 1'b0;
        sat_n    = 1'b0;

        if (up == DIR_UP) begin
            // Compare first so q+1 never overflows WIDTH bits. The >= branch
            // covers both q==max_r and a q left above a lowered bound.
            if (q < max_r) begin
                q_next = q + WIDTH'(1);
            end else if (sat == MODE_SAT) begin
                q_next = max_r;
                sat_n  = 1'b1;
            end else begin
                q_next  = '0;
                carry_n = 1'b1;
            end
        end else begin
            if (q > max_r) begin
                // Out of range: pull back to the bound without a pulse
                q_next = max_r;
            end else if (q != '0) begin
                q_next = q - WIDTH'(1);
            end else if (sat == MODE_SAT) begin
                sat_n = 1'b1;
            end else begin
                q_next   = max_r;
                borrow_n = 1'b1;
            end
        end
    end

endmodule : updown_next
`default_nettype wire

// File: rtl/updown_modn_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updown_modn_counter
//  Description : Fully synchronous up/down modulo-N counter with a runtime
//                programmable bound, parallel load and wrap/saturate mode.
//                Ports: clk, rst (sync, active-high), en, up, sat, load,
//                       load_val, max_wr, max_val -> q, qb, tc, ripple_en,
//                       carry, borrow, sat_hit.
//                tc/ripple_en are combinational for cascading; carry,
//                borrow and sat_hit are registered one-cycle pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module updown_modn_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int unsigned MAX_RST = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             max_wr,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             ripple_en,
    output logic             carry,
    output logic             borrow,
    output logic             sat_hit
);

    localparam logic [WIDTH-1:0] c_max_rst = WIDTH'(MAX_RST);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_max;
    logic             r_carry;
    logic             r_borrow;
    logic             r_sat_hit;

    logic [WIDTH-1:0] w_q_next;
    logic             w_carry_n;
    logic             w_borrow_n;
    logic             w_sat_n;
    logic [WIDTH-1:0] w_load_clamped;

    updown_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q        (r_q),
        .max_r    (r_max),
        .up       (up),
        .sat      (sat),
        .q_next   (w_q_next),
        .carry_n  (w_carry_n),
        .borrow_n (w_borrow_n),
        .sat_n    (w_sat_n)
    );

    // Load clamps against the bound in force on this edge, not a bound
    // being written on the same edge.
    assign w_load_clamped = (load_val > r_max) ? r_max : load_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= '0;
            r_max     <= c_max_rst;
            r_carry   <= 1'b0;
            r_borrow  <= 1'b0;
            r_sat_hit <= 1'b0;
        end else begin
            // Bound register is independent of load/enable; q is untouched
            if (max_wr) begin
                r_max <= max_val;
            end

            if (load) begin
                r_q       <= w_load_clamped;
                r_carry   <= 1'b0;
                r_borrow  <= 1'b0;
                r_sat_hit <= 1'b0;
            end else if (en) begin
                r_q       <= w_q_next;
                r_carry   <= w_carry_n;
                r_borrow  <= w_borrow_n;
                r_sat_hit <= w_sat_n;
            end else begin
                r_carry   <= 1'b0;
                r_borrow  <= 1'b0;
                r_sat_hit <= 1'b0;
            end
        end
    end

    assign q         = r_q;
    assign qb        = ~r_q;
    assign tc        = (up == DIR_UP) ? (r_q == r_max) : (r_q == '0);
    assign ripple_en = en & tc & (sat == MODE_WRAP);
    assign carry     = r_carry;
    assign borrow    = r_borrow;
    assign sat_hit   = r_sat_hit;

endmodule : updown_modn_counter
`default_nettype wire

// File: tb/tb_updown_modn_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updown_modn_counter
//  Description : Directed self-checking bench for updown_modn_counter:
//                one default mod-12 instance plus a two-digit BCD cascade.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_updown_modn_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Single-instance stimulus
    logic       rst = 1'b1, en = 1'b0, up = 1'b1, sat = 1'b0;
    logic       load = 1'b0, max_wr = 1'b0;
    logic [3:0] load_val = '0, max_val = '0;
    logic [3:0] q, qb;
    logic       tc, ripple_en, carry, borrow, sat_hit;

    updown_modn_counter #(.WIDTH(4), .MAX_RST(11)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat),
        .load(load), .load_val(load_val), .max_wr(max_wr), .max_val(max_val),
        .q(q), .qb(qb), .tc(tc), .ripple_en(ripple_en),
        .carry(carry), .borrow(borrow), .sat_hit(sat_hit)
    );

    // BCD cascade: units stage enables the tens stage through ripple_en
    logic       crst = 1'b1, cen = 1'b0;
    logic [3:0] lq, lqb, hq, hqb;
    logic       ltc, lrip, lcy, lbw, lsh;
    logic       htc, hrip, hcy, hbw, hsh;

    updown_modn_counter #(.WIDTH(4), .MAX_RST(9)) u_lo (
        .clk(clk), .rst(crst), .en(cen), .up(1'b1), .sat(1'b0),
        .load(1'b0), .load_val(4'd0), .max_wr(1'b0), .max_val(4'd0),
        .q(lq), .qb(lqb), .tc(ltc), .ripple_en(lrip),
        .carry(lcy), .borrow(lbw), .sat_hit(lsh)
    );

    updown_modn_counter #(.WIDTH(4), .MAX_RST(9)) u_hi (
        .clk(clk), .rst(crst), .en(lrip), .up(1'b1), .sat(1'b0),
        .load(1'b0), .load_val(4'd0), .max_wr(1'b0), .max_val(4'd0),
        .q(hq), .qb(hqb), .tc(htc), .ripple_en(hrip),
        .carry(hcy), .borrow(hbw), .sat_hit(hsh)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge; inputs changed and outputs sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pulses(input string tag, input logic c, input logic b, input logic s);
        check({tag, ".carry"},   carry,   c);
        check({tag, ".borrow"},  borrow,  b);
        check({tag, ".sat_hit"}, sat_hit, s);
    endtask

    initial begin
        // ---- reset state ----
        step();
        check("rst.q", q, 0);
        check("rst.qb", qb, 4'hF);
        check_pulses("rst", 0, 0, 0);
        check("rst.tc_up", tc, 0);
        up = 1'b0; #1;
        check("rst.tc_down", tc, 1);

        // ---- mod-12 up count, 13 cycles ----
        rst = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            step();
            check("up.q", q, i % 12);
            check("up.qb", qb, {28'h0, ~4'(i % 12)});
            check("up.carry", carry, (i % 12) == 0);
        end

        // ---- borrow from 0 ----
        en = 1'b0; load = 1'b1; load_val = 4'd0;
        step();
        check("ld0.q", q, 0);
        load = 1'b0; en = 1'b1; up = 1'b0;
        step();
        check("dn.q", q, 11);
        check_pulses("dn", 0, 1, 0);
        step();
        check("dn2.q", q, 10);
        check("dn2.borrow", borrow, 0);

        // ---- saturate at top ----
        en = 1'b0; sat = 1'b1; load = 1'b1; load_val = 4'd11;
        step();
        check("ld11.q", q, 11);
        check("ld11.sat_hit", sat_hit, 0);
        load = 1'b0; en = 1'b1; up = 1'b1; #1;
        check("sat.tc", tc, 1);
        check("sat.ripple_en", ripple_en, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("sat.q", q, 11);
            check_pulses("sat", 0, 0, 1);
        end
        sat = 1'b0; #1;
        check("wrap.ripple_en", ripple_en, 1);

        // ---- load clamp and load-over-enable priority ----
        en = 1'b0; load = 1'b1; load_val = 4'd14;
        step();
        check("clamp.q", q, 11);
        en = 1'b1; up = 1'b1; load_val = 4'd3;
        step();
        check("ldpri.q", q, 3);
        check_pulses("ldpri", 0, 0, 0);
        load_val = 4'd15;
        step();
        check("ldpri2.q", q, 11);
        check_pulses("ldpri2", 0, 0, 0);

        // ---- lowered bound: q=9, max 5 ----
        en = 1'b0; load_val = 4'd9;
        step();
        load = 1'b0; max_wr = 1'b1; max_val = 4'd5;
        step();
        check("mw.q_unchanged", q, 9);
        max_wr = 1'b0; en = 1'b1; up = 1'b1;
        step();
        check("oor_up.q", q, 0);
        check_pulses("oor_up", 1, 0, 0);

        // Raise to 11, then load 9 while writing 5 on the same edge
        en = 1'b0; max_wr = 1'b1; max_val = 4'd11;
        step();
        load = 1'b1; load_val = 4'd9; max_val = 4'd5;
        step();
        check("ldmw.q", q, 9);
        load = 1'b0; max_wr = 1'b0; en = 1'b1; up = 1'b0;
        step();
        check("oor_dn.q", q, 5);
        check_pulses("oor_dn", 0, 0, 0);

        en = 1'b0; max_wr = 1'b1; max_val = 4'd11;
        step();
        load = 1'b1; load_val = 4'd9; max_val = 4'd5;
        step();
        load = 1'b0; max_wr = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b1;
        step();
        check("oor_sat.q", q, 5);
        check_pulses("oor_sat", 0, 0, 1);

        // ---- max_r = 0 in wrap mode: carry every enabled cycle ----
        sat = 1'b0; en = 1'b0; max_wr = 1'b1; max_val = 4'd0;
        step();
        max_wr = 1'b0; load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("m0.q", q, 0);
            check("m0.carry", carry, 1);
        end
        en = 1'b0;
        step();
        check("hold.carry", carry, 0);

        // ---- reset discards an in-flight max write ----
        rst = 1'b1; max_wr = 1'b1; max_val = 4'd3;
        step();
        check("rstmw.q", q, 0);
        rst = 1'b0; max_wr = 1'b0; load = 1'b1; load_val = 4'd15;
        step();
        check("rstmw.max", q, 11);
        load = 1'b0;

        // ---- BCD cascade 00..99 -> 00 ----
        step();
        check("bcd.rst", {hq, lq}, 8'h00);
        crst = 1'b0; cen = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            check("bcd.val", int'(hq) * 10 + int'(lq), i % 100);
        end
        for (int i = 1; i <= 57; i++) step();
        check("bcd.57", {hq, lq}, 8'h57);
        crst = 1'b1;
        step();
        check("bcd.rst57", {hq, lq}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_updown_modn_counter
`default_nettype wire

// File: doc/updown_modn_counter.md
Name: updown_modn_counter

Overview:
Fully synchronous, parametrised up/down modulo-N counter with a runtime-programmable modulus, parallel load, and a wrap or saturate mode.
It replaces the fixed-width, ripple-clocked JK counter chain: every bit is updated on one clock edge, so there is no ripple skew.
Terminal-count and ripple-enable outputs let several instances cascade into wider counters.
It sits beside the timer and sequencer blocks as the common counting primitive.

Parameters:
WIDTH, 4, counter width in bits (≥1).
MAX_RST, 11, value loaded into the internal max register at reset (default behaviour is mod-12).

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  reset, synchronous, active-high.
en  input  1  count enable.
up  input  1  direction: 1 = increment, 0 = decrement.
sat  input  1  mode: 0 = wrap (modulo), 1 = saturate at the bounds.
load  input  1  parallel load strobe.
load_val  input  WIDTH  value to load.
max_wr  input  1  write strobe for the modulus register.
max_val  input  WIDTH  new upper bound; the modulus is max_val+1.
q  output  WIDTH  count value.
qb  output  WIDTH  always ~q.
tc  output  1  terminal count, combinational: (up & q==max_r) | (~up & q==0).
ripple_en  output  1  en & tc & ~sat; drives en of the next cascaded stage.
carry  output  1  registered one-cycle pulse: wrap from max_r to 0.
borrow  output  1  registered one-cycle pulse: wrap from 0 to max_r.
sat_hit  output  1  registered one-cycle pulse: a step was blocked in saturate mode.

Behaviour:
- Reset values: q=0, qb=all ones, max_r=MAX_RST, carry=0, borrow=0, sat_hit=0.
- Priority on each rising edge: rst > load > en. max_wr is independent of all three.
- max_wr: max_r <= max_val on the edge.
  - The new bound takes effect from the next cycle.
  - q is not modified by the write itself.
- load: q <= min(load_val, max_r), using the max_r value current on that edge.
  - Any count step in the same cycle is ignored.
  - carry, borrow and sat_hit are 0 in the cycle after a load.
- en=1, load=0, q within 0..max_r:
  - up, q<max_r: q+1.
  - up, q==max_r: wrap mode -> 0 with carry=1; sat mode -> hold with sat_hit=1.
  - down, q>0: q-1.
  - down, q==0: wrap mode -> max_r with borrow=1; sat mode -> hold with sat_hit=1.
- Out-of-range case (q>max_r, possible after max_r is lowered), with en=1:
  - up: wrap mode -> 0 with carry=1; sat mode -> max_r with sat_hit=1.
  - down: q <= max_r, no pulse.
- en=0: q holds; all pulses are 0.
- Pulses are exactly one cycle wide. They repeat on consecutive cycles if the condition repeats, e.g. max_r=0 in wrap mode counting up gives carry=1 every enabled cycle while q stays 0.
- up and sat may change on any cycle and take effect on the same edge. tc reflects the current up value.
- Arithmetic is WIDTH-bit unsigned. No intermediate value may overflow: compare before incrementing.
- max_r = all ones in wrap mode gives a natural 2^WIDTH counter.
- Latency: q updates one edge after the request. tc and ripple_en are combinational from q, up, en and max_r.
- Reset mid-count: next edge q=0 and pulses are cleared; an in-flight max_wr is discarded.

Decomposition:
- Shared package counter_pkg:
  - mode constants MODE_WRAP=0, MODE_SAT=1
  - direction constants DIR_DOWN=0, DIR_UP=1
- One natural sub-module, updown_next: purely combinational next-state and pulse logic (q, max_r, up, sat -> q_next, carry_n, borrow_n, sat_n).
- The top level holds the registers, load and enable priority, and the max register.

Test Plan:
- Default parameters, rst then en=1, up=1, sat=0 for 13 cycles -> q = 0,1,…,11,0,1; carry=1 only in the cycle q becomes 0; qb==~q throughout.
- q=0, up=0, en=1, sat=0 -> q=11, borrow=1 for one cycle; next cycle q=10, borrow=0.
- sat=1, load 11, up=1, en=1 for 3 cycles -> q stays 11, sat_hit=1 each cycle, carry=0, ripple_en=0.
- load=1, load_val=14 with max_r=11 -> q=11; load and en asserted together with up=1 -> q=load_val clamped, no step.
- Count to q=9, max_wr with max_val=5, then en=1, up=1 -> q=0 with carry=1; repeat with down -> q=5, no pulse; repeat with sat=1, up -> q=5, sat_hit=1.
- Two instances cascaded (ripple_en -> en), WIDTH=4, max_val=9 -> BCD count 00..99 then 00; rst asserted at count 57 -> both stages 0 on the next edge.
